// File: rtl/tt_mux_slot_ctrl_pkg.sv
// Shared types and packed-bus field layout for the multi-slot pin multiplexer.
// Bus layout: iw = {uio_in, ui_in, rst_n, clk}, ow = {uio_oe, uio_out, uo_out}.
package tt_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFF    = 2'd1,
    ST_ON_RST = 2'd2,
    ST_ACTIVE = 2'd3
  } mux_state_e;

  localparam int IW_W = 18;
  localparam int OW_W = 24;

  localparam int IW_CLK = 0;
  localparam int IW_RST = 1;
  localparam int IW_UI  = 2;
  localparam int IW_UIO = 10;

  localparam int OW_UO      = 0;
  localparam int OW_UIO_OUT = 8;
  localparam int OW_UIO_OE  = 16;

  function automatic logic [IW_W-1:0] pack_iw(input logic [7:0] uio, input logic [7:0] ui,
                                               input logic rst_b, input logic clk_b);
    logic [IW_W-1:0] iw;
    iw             = '0;
    iw[IW_CLK]     = clk_b;
    iw[IW_RST]     = rst_b;
    iw[IW_UI +: 8]  = ui;
    iw[IW_UIO +: 8] = uio;
    return iw;
  endfunction

endpackage

// File: rtl/tt_mux_slot_ctrl_if.sv
// Slot-select handshake and status bundle between a host controller and tt_mux_slot_ctrl.
interface tt_mux_slot_ctrl_if #(
  parameter int SLOT_AW = 2
);
  logic               sel_valid;
  logic [SLOT_AW-1:0] sel_slot;
  logic               sel_ready;
  logic               sel_err;
  logic               busy;
  logic               active_valid;
  logic [SLOT_AW-1:0] active_slot;

  modport master (
    output sel_valid, sel_slot,
    input  sel_ready, sel_err, busy, active_valid, active_slot
  );

  modport slave (
    input  sel_valid, sel_slot,
    output sel_ready, sel_err, busy, active_valid, active_slot
  );
endinterface

// File: rtl/tt_mux_slot_ctrl_rst_seq.sv
// Switchover sequencer: accepts slot requests and walks OFF -> ON_RST -> ACTIVE using a
// down-counter that reloads to RST_CYCLES on every phase entry.
//
// state     | meaning
// IDLE      | no slot enabled, ready for a request
// OFF       | all slots disabled and held in reset
// ON_RST    | target slot enabled, still held in reset
// ACTIVE    | target slot enabled and connected to the pins
module tt_mux_rst_seq
  import tt_mux_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int RST_CYCLES = 4,
  parameter int SLOT_AW    = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel_valid_i,
  input  logic [SLOT_AW-1:0] sel_slot_i,
  output logic               sel_ready_o,
  output logic               sel_err_o,
  output mux_state_e         state_o,
  output logic [SLOT_AW-1:0] target_o
);

  localparam int                 CNT_W       = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD    = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(1);
  localparam logic [SLOT_AW:0]   NUM_SLOTS_W = (SLOT_AW + 1)'(NUM_SLOTS);

  mux_state_e         state_q;
  logic [SLOT_AW-1:0] target_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sel_err_q;
  logic               slot_ok;

  assign slot_ok     = {1'b0, sel_slot_i} < NUM_SLOTS_W;
  assign sel_ready_o = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ACTIVE: begin
          if (sel_valid_i) begin
            if (slot_ok) begin
              target_q <= sel_slot_i;
              cnt_q    <= CNT_LOAD;
              state_q  <= ST_OFF;
            end else begin
              sel_err_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_OFF: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_LOAD;
            state_q <= ST_ON_RST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ON_RST: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_ACTIVE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_err_o = sel_err_q;
  assign state_o   = state_q;
  assign target_o  = target_q;

endmodule

// File: rtl/tt_mux_slot_ctrl.sv
// Multi-slot pin multiplexer: fans host pins out to NUM_SLOTS project wrappers and muxes
// the active slot's outputs back. Optional MUX_OUT_REG_EN registers the pin outputs.
module tt_mux_slot_ctrl
  import tt_mux_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int RST_CYCLES = 4,
  parameter int SLOT_AW    = $clog2(NUM_SLOTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tt_mux_slot_ctrl_if.slave         sel,
  input  logic [7:0]                ui_in_i,
  input  logic [7:0]                uio_in_i,
  input  logic                      proj_rst_n_i,
  output logic [7:0]                uo_out_o,
  output logic [7:0]                uio_out_o,
  output logic [7:0]                uio_oe_o,
  output logic [NUM_SLOTS-1:0]      slot_ena_o,
  output logic [NUM_SLOTS*IW_W-1:0] slot_iw_o,
  input  logic [NUM_SLOTS*OW_W-1:0] slot_ow_i
);

  mux_state_e         state;
  logic [SLOT_AW-1:0] target;
  logic               sel_ready;
  logic               sel_err;
  logic               in_active;
  logic               ena_phase;
  logic [OW_W-1:0]    ow_sel;
  logic [OW_W-1:0]    ow_pins;

  tt_mux_rst_seq #(
    .NUM_SLOTS  (NUM_SLOTS),
    .RST_CYCLES (RST_CYCLES),
    .SLOT_AW    (SLOT_AW)
  ) u_rst_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel_valid_i (sel.sel_valid),
    .sel_slot_i  (sel.sel_slot),
    .sel_ready_o (sel_ready),
    .sel_err_o   (sel_err),
    .state_o     (state),
    .target_o    (target)
  );

  assign in_active = (state == ST_ACTIVE);
  assign ena_phase = (state == ST_ON_RST) || in_active;

  assign sel.sel_ready    = sel_ready;
  assign sel.sel_err      = sel_err;
  assign sel.busy         = (state == ST_OFF) || (state == ST_ON_RST);
  assign sel.active_valid = in_active;
  assign sel.active_slot  = target;

  // Every slot sees the free-running clock; idle slots are parked by ena=0 and rst_n=0.
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    logic is_tgt;
    assign is_tgt        = (target == SLOT_AW'(k));
    assign slot_ena_o[k] = ena_phase && is_tgt;
    assign slot_iw_o[k*IW_W +: IW_W] = (in_active && is_tgt)
                                       ? pack_iw(uio_in_i, ui_in_i, proj_rst_n_i, clk)
                                       : pack_iw(8'h00, 8'h00, 1'b0, clk);
  end

  always_comb begin
    ow_sel = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (target == SLOT_AW'(k)) ow_sel = slot_ow_i[k*OW_W +: OW_W];
    end
  end

`ifdef MUX_OUT_REG_EN
  logic [OW_W-1:0] ow_q;

  // Any request seen in ACTIVE is accepted and leaves ACTIVE, so the register zeroes on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ow_q <= '0;
    end else begin
      ow_q <= (in_active && !sel.sel_valid) ? ow_sel : '0;
    end
  end

  assign ow_pins = ow_q;
`else
  assign ow_pins = in_active ? ow_sel : '0;
`endif

  assign uo_out_o  = ow_pins[OW_UO      +: 8];
  assign uio_out_o = ow_pins[OW_UIO_OUT +: 8];
  assign uio_oe_o  = ow_pins[OW_UIO_OE  +: 8];

endmodule

// File: tb/tb_tt_mux_slot_ctrl.sv
// Self-checking bench for tt_mux_slot_ctrl: directed switchover steps followed by random
// requests, checked against a timeline model. Honours MUX_OUT_REG_EN when defined.
module tb_tt_mux_slot_ctrl;
  import tt_mux_pkg::*;

  localparam int NS  = 5;
  localparam int R   = 4;
  localparam int AW  = $clog2(NS);
  localparam int IWT = NS * IW_W;
  localparam int OWT = NS * OW_W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     ui_in, uio_in;
  logic           proj_rst_n;
  logic [7:0]     uo_out, uio_out, uio_oe;
  logic [NS-1:0]  slot_ena;
  logic [IWT-1:0] slot_iw;
  logic [OWT-1:0] slot_ow;

  int checks   = 0;
  int failures = 0;

  // Model: a selection is a point in time; the phase follows from cycles elapsed since it.
  int cyc, acc_cyc, err_cyc, act;
  bit have;

  tt_mux_slot_ctrl_if #(.SLOT_AW(AW)) sel_if ();

  tt_mux_slot_ctrl #(.NUM_SLOTS(NS), .RST_CYCLES(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (sel_if),
    .ui_in_i      (ui_in),
    .uio_in_i     (uio_in),
    .proj_rst_n_i (proj_rst_n),
    .uo_out_o     (uo_out),
    .uio_out_o    (uio_out),
    .uio_oe_o     (uio_oe),
    .slot_ena_o   (slot_ena),
    .slot_iw_o    (slot_iw),
    .slot_ow_i    (slot_ow)
  );

  always #5 clk = ~clk;

  function automatic int phase();
    int e;
    if (!have) return 0;
    e = cyc - acc_cyc;
    if (e < R) return 1;
    if (e < 2 * R) return 2;
    return 3;
  endfunction

  function automatic logic [23:0] ow_of(input int k);
    return slot_ow[k*24 +: 24];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    have    = 1'b0;
    act     = 0;
    acc_cyc = 0;
    err_cyc = -1000;
  endtask

  task automatic randomize_data();
    ui_in      = 8'($urandom);
    uio_in     = 8'($urandom);
    proj_rst_n = 1'($urandom);
    for (int k = 0; k < NS; k++) slot_ow[k*24 +: 24] = 24'($urandom);
  endtask

  task automatic check_all(input string tag, input logic [23:0] exp_pins);
    int             ph;
    logic [NS-1:0]  exp_ena;
    logic [IWT-1:0] exp_iw;
    ph      = phase();
    exp_ena = '0;
    for (int k = 0; k < NS; k++) begin
      if (ph >= 2 && k == act) exp_ena[k] = 1'b1;
      if (ph == 3 && k == act) exp_iw[k*18 +: 18] = {uio_in, ui_in, proj_rst_n, clk};
      else                     exp_iw[k*18 +: 18] = {17'b0, clk};
    end
    chk({tag, "_ready"},  128'(sel_if.sel_ready),    128'(ph == 0 || ph == 3));
    chk({tag, "_busy"},   128'(sel_if.busy),         128'(ph == 1 || ph == 2));
    chk({tag, "_avalid"}, 128'(sel_if.active_valid), 128'(ph == 3));
    chk({tag, "_aslot"},  128'(sel_if.active_slot),  128'(act));
    chk({tag, "_err"},    128'(sel_if.sel_err),      128'(err_cyc == cyc));
    chk({tag, "_ena"},    128'(slot_ena),            128'(exp_ena));
    chk({tag, "_iw"},     128'(slot_iw),             128'(exp_iw));
    chk({tag, "_uo"},     128'(uo_out),              128'(exp_pins[7:0]));
    chk({tag, "_uioout"}, 128'(uio_out),             128'(exp_pins[15:8]));
    chk({tag, "_uiooe"},  128'(uio_oe),              128'(exp_pins[23:16]));
  endtask

  // Called at a falling edge with data inputs already set; returns at the next falling edge.
  task automatic step(input bit v, input int s, input string tag);
    int          ph_pre, ph;
    logic [23:0] comb_pre, exp_pins;
    sel_if.sel_valid = v;
    sel_if.sel_slot  = AW'(s);
    ph_pre   = phase();
    comb_pre = (ph_pre == 3) ? ow_of(act) : 24'h0;
    @(posedge clk);
    cyc++;
    if ((ph_pre == 0 || ph_pre == 3) && v) begin
      if (s < NS) begin
        have    = 1'b1;
        act     = s;
        acc_cyc = cyc;
      end else begin
        have    = 1'b0;
        err_cyc = cyc;
      end
    end
    @(negedge clk);
    ph = phase();
`ifdef MUX_OUT_REG_EN
    exp_pins = (ph_pre == 3 && ph == 3) ? comb_pre : 24'h0;
`else
    exp_pins = (ph == 3) ? ow_of(act) : 24'h0;
`endif
    check_all(tag, exp_pins);
  endtask

  initial begin
    rst_n            = 1'b0;
    sel_if.sel_valid = 1'b0;
    sel_if.sel_slot  = '0;
    ui_in            = '0;
    uio_in           = '0;
    proj_rst_n       = 1'b0;
    slot_ow          = '0;
    cyc              = 0;
    model_reset();

    @(negedge clk);
    check_all("reset", 24'h0);
    rst_n = 1'b1;

    // Select slot 2: 4 cycles OFF, 4 cycles ON_RST, ACTIVE at acceptance+8.
    randomize_data();
    step(1'b1, 2, "t1_acc");
    for (int i = 1; i <= 2 * R; i++) begin
      randomize_data();
      step(1'b0, 0, "t1_seq");
      if (i == R - 1) chk("t1_ena_off", 128'(slot_ena), 128'(5'b00000));
      if (i == R) begin
        chk("t1_ena_onrst", 128'(slot_ena), 128'(5'b00100));
        chk("t1_rst_held", 128'(slot_iw[2*18 + IW_RST]), 128'(1'b0));
      end
      if (i == 2 * R - 1) chk("t1_not_yet", 128'(sel_if.active_valid), 128'(1'b0));
    end
    chk("t1_active", 128'(sel_if.active_valid), 128'(1'b1));

    // Fixed data on slot 2 while ACTIVE.
    randomize_data();
    ui_in               = 8'hA5;
    slot_ow[2*24 +: 24] = {8'hF0, 8'h3C, 8'h5A};
    step(1'b0, 0, "t2_a");
    step(1'b0, 0, "t2_b");
    chk("t2_uo",    128'(uo_out),                   128'(8'h5A));
    chk("t2_uiooe", 128'(uio_oe),                   128'(8'hF0));
    chk("t2_ui2",   128'(slot_iw[2*18 + IW_UI +: 8]), 128'(8'hA5));
    chk("t2_ui0",   128'(slot_iw[0*18 + IW_UI +: 8]), 128'(8'h00));

    // Switch 2 -> 1 while hammering requests that must be ignored.
    randomize_data();
    step(1'b1, 1, "t3_acc");
    for (int i = 1; i <= 2 * R; i++) begin
      randomize_data();
      step(1'b1, $urandom_range(0, 7), "t3_busy");
      if (i < 2 * R) chk("t3_oe_quiet", 128'(uio_oe), 128'(8'h00));
      chk("t3_onehot", 128'($countones(slot_ena) <= 1), 128'(1'b1));
    end
    chk("t3_slot1", 128'(sel_if.active_slot), 128'(1));

    // Out-of-range index from ACTIVE.
    randomize_data();
    step(1'b1, 5, "t4_err");
    chk("t4_pulse", 128'(sel_if.sel_err), 128'(1'b1));
    chk("t4_ena",   128'(slot_ena),       128'(0));
    step(1'b0, 0, "t4_after");
    chk("t4_pulse_end", 128'(sel_if.sel_err), 128'(1'b0));

    // Asynchronous reset in the middle of ON_RST.
    randomize_data();
    step(1'b1, 3, "t5_acc");
    for (int i = 1; i <= R + 1; i++) begin
      randomize_data();
      step(1'b0, 0, "t5_seq");
    end
    chk("t5_onrst_ena", 128'(slot_ena), 128'(5'b01000));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5_async", 24'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random requests, including out-of-range indices and requests while busy.
    for (int i = 0; i < 600; i++) begin
      randomize_data();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
